// File: rtl/data_buffer_pkg.sv
// Shared types and elaboration helpers for the multi-entry pipeline data buffer.
package data_buffer_pkg;

    localparam int MaxDepth = 64;

    // Wide enough to hold any legal occupancy value, 0..MaxDepth.
    typedef logic [$clog2(MaxDepth + 1) - 1:0] count_t;

    function automatic int ptr_width(input int depth);
        return (depth < 2) ? 1 : $clog2(depth);
    endfunction

    function automatic int count_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    function automatic bit params_legal(input int depth, input int almost_full_th);
        return (depth >= 2) && (depth <= MaxDepth) && ((depth & (depth - 1)) == 0)
            && (almost_full_th >= 1) && (almost_full_th <= depth);
    endfunction

endpackage

// File: rtl/data_buffer_fifo_if.sv
// Producer/consumer handshake bundle for data_buffer_fifo.
interface data_buffer_fifo_if #(
    parameter int DataWidth = 64,
    parameter int Depth     = 4
);
    localparam int CntW = $clog2(Depth + 1);

    logic                 jump;
    logic [DataWidth-1:0] wdata;
    logic                 winc;
    logic                 wfull;
    logic                 walmost_full;
    logic [DataWidth-1:0] rdata;
    logic                 rinc;
    logic                 rempty;
    logic [CntW-1:0]      count;
    logic                 err_overflow;
    logic                 err_underflow;

    modport master (
        output jump, wdata, winc, rinc,
        input  wfull, walmost_full, rdata, rempty, count, err_overflow, err_underflow
    );

    modport slave (
        input  jump, wdata, winc, rinc,
        output wfull, walmost_full, rdata, rempty, count, err_overflow, err_underflow
    );
endinterface

// File: rtl/data_buffer_mem.sv
// Depth x DataWidth register array: one write port, one asynchronous read port,
// asynchronous active-low clear.
module data_buffer_mem #(
    parameter int DataWidth = 64,
    parameter int Depth     = 4,
    parameter int PtrW      = 2
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_we,
    input  logic [PtrW-1:0]      i_waddr,
    input  logic [DataWidth-1:0] i_wdata,
    input  logic [PtrW-1:0]      i_raddr,
    output logic [DataWidth-1:0] o_rdata
);

    logic [DataWidth-1:0] r_mem [Depth];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < Depth; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/data_buffer_fifo.sv
// Multi-entry first-word-fall-through pipeline buffer with optional empty bypass
// and a synchronous flush (jump) for branch redirects.
module data_buffer_fifo
    import data_buffer_pkg::*;
#(
    parameter int DataWidth    = 64,
    parameter int Depth        = 4,
    parameter int AlmostFullTh = 3,
    parameter bit BypassEn     = 1'b1
) (
    input logic               i_clk,
    input logic               i_rst_n,
    data_buffer_fifo_if.slave bus
);

    localparam int PtrW = ptr_width(Depth);
    localparam int CntW = count_width(Depth);

    if (!params_legal(Depth, AlmostFullTh)) begin : g_bad_params
        $error("data_buffer_fifo: Depth must be a power of two in 2..64 and AlmostFullTh in 1..Depth");
    end

    logic [PtrW-1:0]      r_wptr;
    logic [PtrW-1:0]      r_rptr;
    logic [CntW-1:0]      r_count;
    logic                 r_err_ovf;
    logic                 r_err_unf;

    logic                 w_stored_empty;
    logic                 w_full;
    logic                 w_rempty;
    logic                 w_bypass;
    logic                 w_wr_acc;
    logic                 w_rd_acc;
    logic [DataWidth-1:0] w_mem_rdata;
    count_t               w_count_ext;

    assign w_count_ext    = count_t'(r_count);
    assign w_stored_empty = (r_count == '0);
    assign w_full         = (r_count == CntW'(Depth));
    assign w_rempty       = w_stored_empty && !(BypassEn && bus.winc);

    // Empty pass-through: the word goes straight out, nothing is stored.
    assign w_bypass = BypassEn && w_stored_empty && bus.winc && bus.rinc && !bus.jump;
    assign w_wr_acc = bus.winc && !w_full && !bus.jump && !w_bypass;
    assign w_rd_acc = bus.rinc && !w_rempty && !bus.jump && !w_bypass;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_count   <= '0;
            r_err_ovf <= 1'b0;
            r_err_unf <= 1'b0;
        end else begin
            r_err_ovf <= bus.winc && w_full && !bus.jump;
            r_err_unf <= bus.rinc && w_rempty && !bus.jump;
            if (bus.jump) begin
                r_wptr  <= '0;
                r_rptr  <= '0;
                r_count <= '0;
            end else begin
                if (w_wr_acc) begin
                    r_wptr <= r_wptr + PtrW'(1);
                end
                if (w_rd_acc) begin
                    r_rptr <= r_rptr + PtrW'(1);
                end
                if (w_wr_acc && !w_rd_acc) begin
                    r_count <= r_count + CntW'(1);
                end else if (w_rd_acc && !w_wr_acc) begin
                    r_count <= r_count - CntW'(1);
                end
            end
        end
    end

    data_buffer_mem #(
        .DataWidth(DataWidth),
        .Depth    (Depth),
        .PtrW     (PtrW)
    ) u_mem (
        .i_clk  (i_clk),
        .i_rst_n(i_rst_n),
        .i_we   (w_wr_acc),
        .i_waddr(r_wptr),
        .i_wdata(bus.wdata),
        .i_raddr(r_rptr),
        .o_rdata(w_mem_rdata)
    );

    assign bus.rdata         = (BypassEn && w_stored_empty) ? bus.wdata : w_mem_rdata;
    assign bus.wfull         = w_full;
    assign bus.walmost_full  = (w_count_ext >= count_t'(AlmostFullTh));
    assign bus.rempty        = w_rempty;
    assign bus.count         = r_count;
    assign bus.err_overflow  = r_err_ovf;
    assign bus.err_underflow = r_err_unf;

endmodule
